audio_codec_init_seq: RTL and testbench
=======================================

AUDIO_CODEC_INIT_SEQ -- requirements
Module: audio_codec_init_seq

Interface
REQ-001 SHALL have parameter RESET_WAIT, default 1000: cycles waited after reset/start before the first codec write.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: maximum poll cycles per write before error.
REQ-003 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  re-run sequence pulse.
- host_address  in  5  host Avalon-MM address.
- host_select  in  1  host select.
- host_read  in  1  host read.
- host_write  in  1  host write.
- host_writedata  in  32  host write data.
- host_readdata  out  32  host read data.
- host_waitrequest  out  1  host stall.
- m_address  out  5  controller address.
- m_select  out  1  controller select.
- m_read  out  1  controller read.
- m_write  out  1  controller write.
- m_writedata  out  32  controller write data.
- m_readdata  in  32  controller read data, valid the cycle after m_read.
- init_busy  out  1  sequence running.
- init_done  out  1  sequence completed OK.
- init_error  out  1  sequence aborted on timeout.

Function
REQ-004 SHALL issue writes to the audio controller as follows:
- address 0 = I2C command; writedata = {16'h0, reg[6:0], data[8:0]}.
- address 1 = status; bit0 = I2C busy.
REQ-005 SHALL hold an 11-entry fixed table, issued in order (reg:data):
- 0x0F:0x000, 0x00:0x017, 0x01:0x017, 0x02:0x079, 0x03:0x079, 0x04:0x012
- 0x05:0x000, 0x06:0x000, 0x07:0x00A, 0x08:0x000, 0x09:0x001
REQ-006 SHALL implement FSM states WAIT_PWR, WRITE, POLL_RD, POLL_CHK, NEXT, DONE, ERROR.
REQ-007 WAIT_PWR SHALL count RESET_WAIT cycles and then go to WRITE with index 0.
REQ-008 WRITE SHALL assert m_select and m_write with address 0 for exactly one cycle, then go to POLL_RD.
REQ-009 POLL_RD SHALL assert m_select and m_read with address 1 for one cycle, then go to POLL_CHK.
REQ-010 POLL_CHK SHALL sample m_readdata[0]:
- 1: return to POLL_RD.
- 0: go to NEXT.
REQ-011 NEXT SHALL go to WRITE with index+1, or to DONE when index == 10.
REQ-012 The poll counter SHALL reset on entry to WRITE and increment each POLL_CHK cycle. Reaching TIMEOUT_CYCLES SHALL move to ERROR.
REQ-013 Outputs by state:
- init_busy = 1 in WAIT_PWR through NEXT.
- init_done = 1 only in DONE.
- init_error = 1 only in ERROR.
REQ-014 While init_busy, the sequencer SHALL own the m_* bus. Host requests (host_select & (host_read | host_write)) SHALL see host_waitrequest = 1 and have no effect.
REQ-015 In DONE or ERROR, m_* SHALL combinationally equal host_*, host_readdata SHALL equal m_readdata, and host_waitrequest SHALL be 0.
REQ-016 In DONE or ERROR, start = 1 SHALL clear done/error and enter WAIT_PWR with counters zeroed. The host access pending in that same cycle SHALL complete (pass-through is decided from current state).
REQ-017 start SHALL be ignored while init_busy.
REQ-018 m_* SHALL be 0 whenever the sequencer is not driving them and the host path is not selected.

Reset
REQ-019 rst SHALL force state WAIT_PWR with index, wait counter and poll counter = 0, so the sequence auto-starts after reset.
REQ-020 During and immediately after reset, outputs SHALL be: init_busy = 1, init_done = 0, init_error = 0, m_* = 0, host_readdata = 0.
REQ-021 rst asserted mid-sequence SHALL abort it and restart from table entry 0 after RESET_WAIT.

Configuration
REQ-022 Macro AUDIO_INIT_TIMEOUT_EN SHALL control the poll timeout:
- defined: timeout per REQ-012 is active.
- undefined: no poll counter; POLL_CHK waits indefinitely, the ERROR state is unreachable and init_error is tied 0.

Verification (bench: RESET_WAIT=4, TIMEOUT_CYCLES=16, AUDIO_INIT_TIMEOUT_EN defined)
REQ-023 Release rst, status busy for 3 polls per write -> 11 writes in table order, first m_writedata = 0x0000_1E00, last = 0x0000_1201; init_done = 1; no write before cycle 5.
REQ-024 Host write at address 2 during init -> host_waitrequest = 1 until DONE, then the write appears on m_* with waitrequest 0 in the same cycle.
REQ-025 Status stuck busy on write 3 -> ERROR after 16 polls; init_error = 1, init_busy = 0, host pass-through active.
REQ-026 From ERROR, pulse start with status idle -> full 11-write rerun, init_error = 0, init_done = 1.
REQ-027 Assert rst during write 6 -> restart; next write is 0x0000_1E00 after 4 wait cycles.
REQ-028 start pulsed while busy -> ignored; write count stays 11.

Source files
------------

// File: rtl/audio_codec_init_seq.sv
// rtl/audio_codec_init_seq.sv - Codec register init sequencer with host Avalon-MM pass-through
// Optional poll timeout enabled by defining AUDIO_INIT_TIMEOUT_EN.
module audio_codec_init_seq #(
    parameter int RESET_WAIT     = 1000,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  host_address,
    input  logic        host_select,
    input  logic        host_read,
    input  logic        host_write,
    input  logic [31:0] host_writedata,
    output logic [31:0] host_readdata,
    output logic        host_waitrequest,
    output logic [4:0]  m_address,
    output logic        m_select,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        init_busy,
    output logic        init_done,
    output logic        init_error
);
    typedef enum logic [2:0] {
        S_WAIT_PWR, S_WRITE, S_POLL_RD, S_POLL_CHK, S_NEXT, S_DONE, S_ERROR
    } state_t;

    // One counter serves both the power-up wait and the per-write poll count.
    localparam int CNT_MAX = (RESET_WAIT > TIMEOUT_CYCLES) ? RESET_WAIT : TIMEOUT_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((RESET_WAIT > 0) ? RESET_WAIT - 1 : 0);
    localparam logic [3:0]       LAST_IDX  = 4'd10;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             w_timeout;

`ifdef AUDIO_INIT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    assign w_timeout = (r_cnt >= TIMEOUT_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    function automatic logic [15:0] f_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    f_entry = {7'h0F, 9'h000};
            4'd1:    f_entry = {7'h00, 9'h017};
            4'd2:    f_entry = {7'h01, 9'h017};
            4'd3:    f_entry = {7'h02, 9'h079};
            4'd4:    f_entry = {7'h03, 9'h079};
            4'd5:    f_entry = {7'h04, 9'h012};
            4'd6:    f_entry = {7'h05, 9'h000};
            4'd7:    f_entry = {7'h06, 9'h000};
            4'd8:    f_entry = {7'h07, 9'h00A};
            4'd9:    f_entry = {7'h08, 9'h000};
            4'd10:   f_entry = {7'h09, 9'h001};
            default: f_entry = 16'h0000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_WAIT_PWR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT_PWR: if (r_cnt >= WAIT_LAST) w_next = S_WRITE;
            S_WRITE:    w_next = S_POLL_RD;
            S_POLL_RD:  w_next = S_POLL_CHK;
            S_POLL_CHK: begin
                // A final idle status wins over a timeout reached on the same poll.
                if (!m_readdata[0])  w_next = S_NEXT;
                else if (w_timeout)  w_next = S_ERROR;
                else                 w_next = S_POLL_RD;
            end
            S_NEXT:     w_next = (r_idx == LAST_IDX) ? S_DONE : S_WRITE;
            S_DONE,
            S_ERROR:    if (start) w_next = S_WAIT_PWR;
            default:    w_next = S_WAIT_PWR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_WAIT_PWR: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_idx <= '0;
                end
                S_WRITE:    r_cnt <= '0;
`ifdef AUDIO_INIT_TIMEOUT_EN
                S_POLL_CHK: r_cnt <= r_cnt + 1'b1;
`endif
                S_NEXT:     if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
                S_DONE,
                S_ERROR: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    // Reset forces the quiet bus values combinationally, even mid-transfer.
    always_comb begin
        init_busy        = 1'b0;
        init_done        = 1'b0;
        init_error       = 1'b0;
        host_waitrequest = 1'b0;
        host_readdata    = '0;
        m_address        = '0;
        m_select         = 1'b0;
        m_read           = 1'b0;
        m_write          = 1'b0;
        m_writedata      = '0;
        if (rst) begin
            init_busy        = 1'b1;
            host_waitrequest = 1'b1;
        end else begin
            case (r_state)
                S_WRITE: begin
                    init_busy        = 1'b1;
                    host_waitrequest = 1'b1;
                    m_select         = 1'b1;
                    m_write          = 1'b1;
                    m_writedata      = {16'h0000, f_entry(r_idx)};
                end
                S_POLL_RD: begin
                    init_busy        = 1'b1;
                    host_waitrequest = 1'b1;
                    m_select         = 1'b1;
                    m_read           = 1'b1;
                    m_address        = 5'd1;
                end
                S_DONE, S_ERROR: begin
                    init_done     = (r_state == S_DONE);
`ifdef AUDIO_INIT_TIMEOUT_EN
                    init_error    = (r_state == S_ERROR);
`endif
                    m_address     = host_address;
                    m_select      = host_select;
                    m_read        = host_read;
                    m_write       = host_write;
                    m_writedata   = host_writedata;
                    host_readdata = m_readdata;
                end
                default: begin
                    init_busy        = 1'b1;
                    host_waitrequest = 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_audio_codec_init_seq.sv
// tb/tb_audio_codec_init_seq.sv - Self-checking bench for audio_codec_init_seq
// Timeout checks follow AUDIO_INIT_TIMEOUT_EN as seen by this file.
module tb_audio_codec_init_seq;
    localparam int RW = 4;
    localparam int TO = 16;
`ifdef AUDIO_INIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int PH_NONE = 0, PH_BUSY = 1, PH_DONE = 2, PH_ERR = 3;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [4:0]  host_address = '0;
    logic        host_select = 1'b0, host_read = 1'b0, host_write = 1'b0;
    logic [31:0] host_writedata = '0, m_readdata = '0;
    logic [31:0] host_readdata, m_writedata;
    logic        host_waitrequest, m_select, m_read, m_write;
    logic [4:0]  m_address;
    logic        init_busy, init_done, init_error;

    audio_codec_init_seq #(.RESET_WAIT(RW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start),
        .host_address(host_address), .host_select(host_select), .host_read(host_read),
        .host_write(host_write), .host_writedata(host_writedata),
        .host_readdata(host_readdata), .host_waitrequest(host_waitrequest),
        .m_address(m_address), .m_select(m_select), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata),
        .init_busy(init_busy), .init_done(init_done), .init_error(init_error)
    );

    always #5 clk = ~clk;

    int t_reg [11] = '{'h0F, 'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07, 'h08, 'h09};
    int t_dat [11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h000, 'h00A, 'h000, 'h001};

    function automatic logic [31:0] word(input int i);
        word = 32'((t_reg[i] << 9) | t_dat[i]);
    endfunction

    int checks = 0, errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Stimulus configuration shared by the responder and the model.
    int busy_polls = 3;
    bit stuck_en   = 1'b0;
    int stuck_idx  = 3;

    // Controller responder: status busy for busy_polls reads per write, or forever when stuck.
    int          wr_count = 0, poll_k = 0;
    logic [31:0] last_wr = '0;
    logic        rd_pend = 1'b0, rd_busy = 1'b0;
    logic [4:0]  rd_addr = '0;
    always @(negedge clk) begin
        rd_pend <= m_select && m_read;
        rd_addr <= m_address;
        rd_busy <= (poll_k < busy_polls) || (stuck_en && last_wr == word(stuck_idx));
        if (m_select && m_write && m_address == 5'd0) begin
            wr_count <= wr_count + 1;
            last_wr  <= m_writedata;
            poll_k   <= 0;
        end else if (m_select && m_read && m_address == 5'd1) begin
            poll_k <= poll_k + 1;
        end
    end
    always @(posedge clk) begin
        #2;
        if (rd_pend) m_readdata = (rd_addr == 5'd1) ? {31'd0, rd_busy} : (32'hA5A5_0000 | 32'(rd_addr));
    end

    // Schedule model: write k sits at cycle mw; each completed write costs 2*polls+2 cycles.
    int mph = PH_NONE, midx = 0, mw = 0;
    always @(posedge clk) begin
        if (rst) begin
            mph <= PH_BUSY; midx <= 0; mw <= cyc + 1 + RW;
        end else if (mph == PH_BUSY) begin
            if (stuck_en && midx == stuck_idx) begin
                if (TO_EN && cyc == mw + 2 * TO) mph <= PH_ERR;
            end else if (cyc == mw + 2 * (busy_polls + 1) + 1) begin
                midx <= midx + 1;
                mw   <= cyc + 1;
                if (midx == 10) mph <= PH_DONE;
            end
        end else if (mph != PH_NONE && start) begin
            mph <= PH_BUSY; midx <= 0; mw <= cyc + 1 + RW;
        end
        cyc <= cyc + 1;
    end

    logic [75:0] c_act, c_exp, c_mask;
    int          c_off;
    logic        c_wr, c_rd, c_req, c_stuck;
    always @(negedge clk) begin
        c_act = {init_busy, init_done, init_error, host_waitrequest, m_select, m_read, m_write,
                 m_address, m_writedata, host_readdata};
        c_req = host_select && (host_read || host_write);
        if (rst) begin
            c_mask = ~(76'd1 << 72);
            c_exp  = {3'b100, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0};
            check("reset_outputs", c_act & c_mask, c_exp & c_mask);
        end else if (mph == PH_BUSY) begin
            c_off   = cyc - mw;
            c_stuck = stuck_en && midx == stuck_idx;
            c_wr    = (c_off == 0);
            c_rd    = c_off > 0 && (c_off % 2) == 1 &&
                      (c_stuck ? (!TO_EN || c_off < 2 * TO) : c_off < 2 * (busy_polls + 1));
            c_mask  = {3'b111, c_req, 40'hFF_FFFF_FFFF, 32'd0};
            c_exp   = {3'b100, 1'b1, c_wr | c_rd, c_rd, c_wr, c_rd ? 5'd1 : 5'd0,
                       c_wr ? word(midx) : 32'd0, 32'd0};
            check("busy_cycle", c_act & c_mask, c_exp & c_mask);
        end else if (mph != PH_NONE) begin
            c_exp = {1'b0, mph == PH_DONE, mph == PH_ERR, 1'b0, host_select, host_read, host_write,
                     host_address, host_writedata, m_readdata};
            check("passthru_cycle", c_act, c_exp);
        end
    end

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(output int at);
        next_cycle(); start = 1'b1; at = cyc;
        next_cycle(); start = 1'b0;
    endtask

    task automatic count_to_write(output int idle, output logic [31:0] data);
        idle = -1; data = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_write) begin idle = i; data = m_writedata; break; end
        end
    endtask

    task automatic wait_end(input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (init_done || init_error) begin at = cyc; break; end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int idle, at, rel, st, base;
        logic [31:0] d;

        // Power-up run with a host write stalled until DONE and a start ignored while busy.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rel = cyc;
        count_to_write(idle, d);
        check("first_write_idle", 76'(idle), 76'(4));
        check("first_write_data", 76'(d), 76'h1E00);
        pulse_start(st);
        host_select = 1'b1; host_write = 1'b1; host_address = 5'd2; host_writedata = 32'hDEAD_BEEF;
        at = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!host_waitrequest) begin at = cyc; break; end
        end
        check("host_wr_at_done", {init_done, m_select, m_write, m_address, m_writedata},
              {1'b1, 1'b1, 1'b1, 5'd2, 32'hDEAD_BEEF});
        check("done_latency", 76'(at - rel), 76'(114));
        next_cycle();
        host_select = 1'b0; host_write = 1'b0; host_address = '0; host_writedata = '0;
        check("write_count", 76'(wr_count), 76'(11));
        check("last_write_data", 76'(last_wr), 76'h1201);

        // Status stuck busy on write 3.
        busy_polls = 3; stuck_en = 1'b1; stuck_idx = 3; base = wr_count;
        pulse_start(st);
`ifdef AUDIO_INIT_TIMEOUT_EN
        wait_end(1000, at);
        check("error_flags", {init_busy, init_done, init_error}, 76'b001);
        next_cycle();
        check("stuck_polls", 76'(poll_k), 76'(16));
        check("writes_before_error", 76'(wr_count - base), 76'(4));
        host_select = 1'b1; host_read = 1'b1; host_address = 5'd5;
        next_cycle();
        host_select = 1'b0; host_read = 1'b0; host_address = '0;
        @(negedge clk);
        check("error_host_read", 76'(host_readdata), 76'hA5A5_0005);
`else
        repeat (2 * TO + 80) @(negedge clk);
        check("stuck_no_timeout", {init_busy, init_done, init_error}, 76'b100);
        check("stuck_polls_exceed", 76'(poll_k > TO), 76'(1));
        next_cycle(); rst = 1'b1; stuck_en = 1'b0;
        next_cycle(); rst = 1'b0;
        wait_end(2000, at);
        check("recovered_done", 76'(init_done), 76'(1));
`endif

        // Rerun with status always idle.
        stuck_en = 1'b0; busy_polls = 0;
        next_cycle(); base = wr_count;
        pulse_start(st);
        wait_end(1000, at);
        check("rerun_flags", {init_busy, init_done, init_error}, 76'b010);
        check("rerun_latency", 76'(at - st - 1), 76'(48));
        next_cycle();
        check("rerun_writes", 76'(wr_count - base), 76'(11));

        // Reset while write 6 is polling.
        busy_polls = 3; base = wr_count;
        pulse_start(st);
        at = -1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (wr_count - base == 7) begin at = cyc; break; end
        end
        check("reached_write6", 76'(at != -1), 76'(1));
        next_cycle(); rst = 1'b1;
        next_cycle();
        next_cycle(); rst = 1'b0; base = wr_count;
        count_to_write(idle, d);
        check("restart_idle", 76'(idle), 76'(4));
        check("restart_data", 76'(d), 76'h1E00);
        wait_end(1000, at);
        check("restart_done", {init_busy, init_done, init_error}, 76'b010);
        next_cycle();
        check("restart_writes", 76'(wr_count - base), 76'(11));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
